// File: rtl/write_data_serializer_pkg.sv
// Shared types and default geometry for the write-data path (queue and serializer).
package write_data_serializer_pkg;

  localparam int DEF_WIDTH      = 1024;
  localparam int DEF_BEAT_WIDTH = 128;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/write_data_serializer.sv
// Pops one WIDTH-bit entry from the upstream queue tail and emits it as NBEATS LSB-first beats; first beat 1 cycle after pop.
// Beats hold while beat_ready is low; the next entry is popped on the last-beat handshake for zero-bubble streaming.
module write_data_serializer
  import write_data_serializer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int BEAT_WIDTH = DEF_BEAT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  pop,
  output logic                  beat_valid,
  output logic [BEAT_WIDTH-1:0] beat_data,
  output logic                  beat_last,
  input  logic                  beat_ready,
  output logic                  busy,
  output logic [15:0]           entry_cnt
);

  localparam int NBEATS = WIDTH / BEAT_WIDTH;
  localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

  state_t                            state_q, state_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [WIDTH-1:0]                  hold_q, hold_d;
  logic [15:0]                       cnt_q, cnt_d;
  logic [NBEATS-1:0][BEAT_WIDTH-1:0] hold_beats;
  logic                              at_last;

  assign hold_beats = hold_q;
  assign at_last    = (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: pop = in_valid;
      SEND: begin
        if (beat_ready) begin
          if (!at_last) begin
            idx_d = idx_q + IDX_W'(1);
          end else begin
            cnt_d = cnt_q + 16'd1;
            if (in_valid) pop = 1'b1;
            else          state_d = IDLE;
          end
        end
      end
    endcase
    // Reset is asynchronous, so pop must be masked combinationally too.
    if (rst) pop = 1'b0;
    if (pop) begin
      hold_d  = in_data;
      idx_d   = '0;
      state_d = SEND;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Data payload is qualified by beat_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  assign beat_valid = (state_q == SEND);
  assign busy       = (state_q == SEND);
  assign beat_last  = beat_valid && at_last;
  assign beat_data  = hold_beats[idx_q];
  assign entry_cnt  = cnt_q;

endmodule

// File: doc/write_data_serializer.md
WRITE_DATA_SERIALIZER -- requirements
Module: write_data_serializer

Interface
REQ-001 Parameter WIDTH, default 1024: bit width of one queue entry, matching the upstream shift-register queue.
REQ-002 Parameter BEAT_WIDTH, default 128: width of one downstream beat; WIDTH SHALL be an integer multiple of BEAT_WIDTH, with NBEATS = WIDTH/BEAT_WIDTH (default 8).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  upstream queue tail holds a valid entry (upstream out_valid).
REQ-006 in_data  input  WIDTH  upstream tail entry (upstream data_out).
REQ-007 pop  output  1  combinational; removes the tail entry from upstream in this cycle.
REQ-008 beat_valid  output  1  beat_data is valid this cycle.
REQ-009 beat_data  output  BEAT_WIDTH  current beat.
REQ-010 beat_last  output  1  current beat is beat NBEATS-1 of its entry.
REQ-011 beat_ready  input  1  downstream accepts the beat this cycle.
REQ-012 busy  output  1  high whenever state is SEND.
REQ-013 entry_cnt  output  16  count of fully transmitted entries; wraps from 0xFFFF to 0.

Function
REQ-014 FSM has two states, IDLE and SEND; beat_valid SHALL equal (state==SEND).
REQ-015 A beat handshake occurs in a cycle with beat_valid && beat_ready.
REQ-016 IDLE: pop = in_valid; when pop=1, in_data SHALL be latched into the hold register, beat index set to 0 and state set to SEND at the same edge.
REQ-017 IDLE with in_valid=0: no state change, pop=0.
REQ-018 beat_data SHALL be hold[idx*BEAT_WIDTH +: BEAT_WIDTH], sent LSB slice first (idx 0..NBEATS-1).
REQ-019 beat_data and beat_last SHALL stay stable while beat_valid && !beat_ready (no drop, no advance).
REQ-020 Handshake with idx<NBEATS-1: idx increments by 1, state stays SEND, pop=0.
REQ-021 Handshake with idx==NBEATS-1: entry_cnt increments by 1; if in_valid=1 then pop=1, the new entry is latched, idx becomes 0 and state stays SEND (zero-bubble back-to-back); otherwise pop=0 and state becomes IDLE.
REQ-022 pop SHALL never be asserted in SEND except under REQ-021, and never when in_valid=0; at most one pop per transmitted entry.
REQ-023 Latency: first beat valid 1 cycle after the pop cycle; an entry takes NBEATS cycles minimum when beat_ready is held high.
REQ-024 beat_ready while beat_valid=0 SHALL be ignored.

Reset
REQ-025 While rst=1, independent of clk: state=IDLE, idx=0, entry_cnt=0, beat_valid=0, beat_last=0, busy=0; pop=0 is forced.
REQ-026 The hold register SHALL NOT be reset; beat_data is don't-care while beat_valid=0.
REQ-027 Reset mid-entry discards the remaining beats; after release, the next pop fetches the current upstream tail.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE, SEND) and default WIDTH/BEAT_WIDTH constants, shared with the queue.
REQ-029 Single module with no sub-module; idx width is clog2(NBEATS).

Verification
REQ-030 Single entry: in_data = {8 beats 0x..07 down to 0x..00}, in_valid for 1 cycle, beat_ready=1 -> pop high 1 cycle; beats 0..7 on 8 consecutive cycles; beat_last only on beat 7; entry_cnt=1; return to IDLE.
REQ-031 Back-to-back: 3 entries queued, beat_ready=1 -> exactly 3 pops; 24 consecutive beats with no bubble; entry_cnt=3.
REQ-032 Backpressure: beat_ready low on cycles 2-4 of an entry -> beat 1 held stable for 3 cycles; no pop; completes in 11 cycles.
REQ-033 Empty source: in_valid=0 for 20 cycles -> pop=0, beat_valid=0, entry_cnt unchanged.
REQ-034 Reset mid-entry: assert rst after beat 3 -> beat_valid=0 immediately (asynchronously), entry_cnt=0; after release with in_valid=1, a fresh pop occurs and beat 0 of the new entry is sent.
REQ-035 Wrap: preload traffic of 65536 entries -> entry_cnt reads 0 after the last beat_last handshake.
